// File: rtl/obstacle_lane_runner.sv
// Falling-obstacle engine for the three-lane car game: spawns one obstacle,
// steps it down the rows, flags collisions and emits one score pulse per pass.
//
// state   | meaning
// IDLE    | waiting for Start, obstacle parked
// SPAWN   | one cycle: obstacle placed at row 0 in a pseudo-random lane
// FALL    | obstacle steps down one row every TICKS_PER_STEP cycles
// CRASHED | collision seen, play frozen until reset
// HALT    | score counter reported game over, play frozen until reset
module obstacle_lane_runner #(
   parameter int TICKS_PER_STEP = 2500000,
   parameter int Y_MAX          = 15,
   parameter int PLAYER_ROW     = 13
) (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic       Start,
   input  logic [1:0] PlayerLane,
   input  logic       GameOver,
   output logic [1:0] ObsLane,
   output logic [3:0] ObsRow,
   output logic       ScorePulse,
   output logic       Crash,
   output logic       Active
);

   localparam int CW = $clog2(TICKS_PER_STEP);
   localparam logic [CW-1:0] STEP_LAST  = CW'(TICKS_PER_STEP - 1);
   localparam logic [3:0]    ROW_LAST   = 4'(Y_MAX);
   localparam logic [3:0]    ROW_PLAYER = 4'(PLAYER_ROW);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SPAWN   = 3'd1,
      FALL    = 3'd2,
      CRASHED = 3'd3,
      HALT    = 3'd4
   } state_t;

   state_t        state, state_next;
   logic [7:0]    lfsr;
   logic [CW-1:0] step_cnt, step_cnt_next;
   logic [1:0]    lane_next;
   logic [3:0]    row_next;
   logic          pulse_next;
   logic          crash_next;
   logic [1:0]    spawn_lane;
   logic [1:0]    player_lane_eff;
   logic          step;
   logic          hit;

   // Lane 3 does not exist on the road: the generator folds it onto the
   // middle lane, while a player lane of 3 is read as the rightmost lane.
   assign spawn_lane      = (lfsr[1:0] == 2'd3) ? 2'd1 : lfsr[1:0];
   assign player_lane_eff = (PlayerLane == 2'd3) ? 2'd2 : PlayerLane;

   assign step   = (state == FALL) && (step_cnt == STEP_LAST);
   assign hit    = (state == FALL) && (ObsRow == ROW_PLAYER) && (ObsLane == player_lane_eff);
   assign Active = (state == SPAWN) || (state == FALL);

   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         lfsr <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         step_cnt   <= '0;
         ObsLane    <= 2'd0;
         ObsRow     <= 4'd0;
         ScorePulse <= 1'b0;
         Crash      <= 1'b0;
      end else begin
         state      <= state_next;
         step_cnt   <= step_cnt_next;
         ObsLane    <= lane_next;
         ObsRow     <= row_next;
         ScorePulse <= pulse_next;
         Crash      <= crash_next;
      end
   end

   always_comb begin
      state_next    = state;
      step_cnt_next = step_cnt;
      lane_next     = ObsLane;
      row_next      = ObsRow;
      pulse_next    = 1'b0;
      crash_next    = Crash;

      case (state)
         IDLE: begin
            if (GameOver) begin
               state_next = HALT;
            end else if (Start) begin
               state_next = SPAWN;
            end
         end
         SPAWN: begin
            row_next      = 4'd0;
            lane_next     = spawn_lane;
            step_cnt_next = '0;
            state_next    = GameOver ? HALT : FALL;
         end
         FALL: begin
            step_cnt_next = step ? '0 : step_cnt + 1'b1;
            // A crash outranks game over; game over outranks a pass.
            if (hit) begin
               state_next = CRASHED;
               crash_next = 1'b1;
            end else if (GameOver) begin
               state_next = HALT;
            end else if (step && (ObsRow == ROW_LAST)) begin
               state_next = SPAWN;
               pulse_next = 1'b1;
            end else if (step) begin
               row_next = ObsRow + 4'd1;
            end
         end
         CRASHED: begin
            crash_next = 1'b1;
         end
         HALT: begin
            crash_next = 1'b0;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_obstacle_lane_runner.sv
// Self-checking bench for obstacle_lane_runner: scripted games with a reference
// LFSR, a small score counter and queues of expected lanes/rows.
module tb_obstacle_lane_runner;

   localparam int T  = 4;
   localparam int Y  = 5;
   localparam int PR = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] plane;
   logic       go_drv;
   logic       use_sc;
   logic       go_in;
   logic [1:0] obs_lane;
   logic [3:0] obs_row;
   logic       score_pulse;
   logic       crash;
   logic       active;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_lfsr;
   int         score;
   logic [1:0] lane_q[$];
   logic [4:0] rp_q[$];

   always #5 clk = ~clk;

   obstacle_lane_runner #(.TICKS_PER_STEP(T), .Y_MAX(Y), .PLAYER_ROW(PR)) dut (
      .CLOCK_50  (clk),
      .Reset     (rst),
      .Start     (start),
      .PlayerLane(plane),
      .GameOver  (go_in),
      .ObsLane   (obs_lane),
      .ObsRow    (obs_row),
      .ScorePulse(score_pulse),
      .Crash     (crash),
      .Active    (active)
   );

   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= 8'hA5;
      else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   always @(posedge clk or posedge rst) begin
      if (rst) score <= 0;
      else if (score_pulse && score < 15) score <= score + 1;
   end

   assign go_in = use_sc ? (score >= 10) : go_drv;

   function automatic logic [1:0] map_lane(input logic [7:0] v);
      return (v[1:0] == 2'd3) ? 2'd1 : v[1:0];
   endfunction

   function automatic logic [1:0] next_lane(input logic [1:0] l);
      return (l == 2'd2) ? 2'd0 : l + 2'd1;
   endfunction

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; go_drv = 1'b0; use_sc = 1'b0; plane = 2'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      lane_q.delete();
      rp_q.delete();
   endtask

   // Raises Start and waits for SPAWN; records the lane the spawn should pick.
   task automatic start_game(output logic [1:0] lane, output bit ok);
      start = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (active) begin ok = 1'b1; break; end
      end
      start = 1'b0;
      lane = map_lane(m_lfsr);
      lane_q.push_back(lane);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; go_drv = 1'b0; use_sc = 1'b0; plane = 2'd0;
      @(negedge clk);
      checks++;
      if ({obs_lane, obs_row, score_pulse, crash, active} !== 9'd0) begin
         errors++;
         $display("FAIL reset_outputs: got lane=%0d row=%0d pulse=%b crash=%b active=%b, need all 0",
                  obs_lane, obs_row, score_pulse, crash, active);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (active !== 1'b0 || obs_row !== 4'd0) begin
         errors++;
         $display("FAIL idle_hold: got active=%b row=%0d, need 0/0", active, obs_row);
      end
   endtask

   task automatic test_pass();
      logic [1:0] lane, got;
      logic [4:0] e;
      bit ok;
      do_reset();
      start_game(lane, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL pass_spawn_timeout: got no SPAWN, need SPAWN"); end
      checks++;
      if (score_pulse !== 1'b0) begin
         errors++; $display("FAIL first_spawn_pulse: got %b, need 0", score_pulse);
      end
      plane = next_lane(lane);
      for (int i = 0; i < Y * T + T; i++) rp_q.push_back({4'(i / T), 1'b0});
      rp_q.push_back({4'(Y), 1'b1});
      rp_q.push_back({4'd0, 1'b0});
      for (int i = 0; i < (Y + 1) * T + 2; i++) begin
         @(negedge clk);
         if (i == 0) begin
            got = lane_q.pop_front();
            checks++;
            if (obs_lane !== got) begin
               errors++; $display("FAIL pass_lane: got %0d, need %0d", obs_lane, got);
            end
         end
         e = rp_q.pop_front();
         checks++;
         if (obs_row !== e[4:1] || score_pulse !== e[0]) begin
            errors++;
            $display("FAIL pass_row_pulse[%0d]: got row=%0d pulse=%b, need row=%0d pulse=%b",
                     i, obs_row, score_pulse, e[4:1], e[0]);
         end
      end
   endtask

   task automatic test_crash();
      logic [1:0] lane, got;
      bit ok;
      int bad;
      do_reset();
      start_game(lane, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL crash_spawn_timeout: got no SPAWN, need SPAWN"); end
      plane = lane;
      for (int i = 0; i <= PR * T + 1; i++) begin
         @(negedge clk);
         if (i == 0) begin
            got = lane_q.pop_front();
            checks++;
            if (obs_lane !== got) begin
               errors++; $display("FAIL crash_lane: got %0d, need %0d", obs_lane, got);
            end
         end
         if (i == PR * T) begin
            checks++;
            if (obs_row !== 4'(PR) || crash !== 1'b0) begin
               errors++; $display("FAIL crash_pre: got row=%0d crash=%b, need row=%0d crash=0", obs_row, crash, PR);
            end
         end
         if (i == PR * T + 1) begin
            checks++;
            if (crash !== 1'b1 || active !== 1'b0 || obs_row !== 4'(PR)) begin
               errors++;
               $display("FAIL crash_set: got crash=%b active=%b row=%0d, need 1/0/%0d", crash, active, obs_row, PR);
            end
         end
      end
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (crash !== 1'b1 || score_pulse !== 1'b0 || obs_row !== 4'(PR) || obs_lane !== lane || active !== 1'b0)
            bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL crash_frozen: got %0d bad cycles, need 0", bad); end
      rst = 1'b1;
      #1;
      checks++;
      if (crash !== 1'b0 || active !== 1'b0) begin
         errors++; $display("FAIL crash_reset: got crash=%b active=%b, need 0/0", crash, active);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_steer();
      logic [1:0] lane, got;
      bit ok;
      do_reset();
      start_game(lane, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL steer_spawn_timeout: got no SPAWN, need SPAWN"); end
      plane = next_lane(lane);
      for (int i = 0; i <= PR * T + 3; i++) begin
         @(negedge clk);
         if (i == 0) begin
            got = lane_q.pop_front();
            checks++;
            if (obs_lane !== got) begin
               errors++; $display("FAIL steer_lane: got %0d, need %0d", obs_lane, got);
            end
         end
         if (i == PR * T + 2) begin
            checks++;
            if (crash !== 1'b0 || obs_row !== 4'(PR)) begin
               errors++; $display("FAIL steer_pre: got crash=%b row=%0d, need 0/%0d", crash, obs_row, PR);
            end
            plane = lane;
         end
         if (i == PR * T + 3) begin
            checks++;
            if (crash !== 1'b1 || active !== 1'b0) begin
               errors++; $display("FAIL steer_crash: got crash=%b active=%b, need 1/0", crash, active);
            end
         end
      end
   endtask

   task automatic test_gameover_pass();
      logic [1:0] lane;
      bit ok;
      int bad;
      do_reset();
      start_game(lane, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL go_spawn_timeout: got no SPAWN, need SPAWN"); end
      plane = next_lane(lane);
      void'(lane_q.pop_front());
      for (int i = 0; i < (Y + 1) * T; i++) @(negedge clk);
      checks++;
      if (obs_row !== 4'(Y)) begin errors++; $display("FAIL go_row_last: got %0d, need %0d", obs_row, Y); end
      go_drv = 1'b1;
      @(negedge clk);
      checks++;
      if (active !== 1'b0 || score_pulse !== 1'b0 || obs_row !== 4'(Y) || crash !== 1'b0) begin
         errors++;
         $display("FAIL go_halt: got active=%b pulse=%b row=%0d crash=%b, need 0/0/%0d/0",
                  active, score_pulse, obs_row, crash, Y);
      end
      go_drv = 1'b0;
      start = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (active !== 1'b0 || score_pulse !== 1'b0 || obs_row !== 4'(Y)) bad++;
      end
      start = 1'b0;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL go_halt_hold: got %0d bad cycles, need 0", bad); end
   endtask

   task automatic test_gameover_idle();
      do_reset();
      go_drv = 1'b1;
      @(negedge clk);
      go_drv = 1'b0;
      start = 1'b1;
      repeat (5) @(negedge clk);
      start = 1'b0;
      checks++;
      if (active !== 1'b0 || obs_row !== 4'd0 || score_pulse !== 1'b0) begin
         errors++;
         $display("FAIL go_idle: got active=%b row=%0d pulse=%b, need 0/0/0", active, obs_row, score_pulse);
      end
   endtask

   task automatic test_score_chain();
      logic [1:0] lane, got;
      bit ok, pend;
      int pulses;
      do_reset();
      use_sc = 1'b1;
      start_game(lane, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL chain_spawn_timeout: got no SPAWN, need SPAWN"); end
      plane = next_lane(lane);
      pend = 1'b1;
      pulses = 0;
      for (int i = 0; i < 11 * ((Y + 1) * T + 1) + 20; i++) begin
         @(negedge clk);
         if (pend && lane_q.size() > 0) begin
            got = lane_q.pop_front();
            pend = 1'b0;
            checks++;
            if (obs_lane !== got) begin
               errors++; $display("FAIL chain_lane: got %0d, need %0d", obs_lane, got);
            end
         end
         if (score_pulse === 1'b1) begin
            pulses++;
            lane = map_lane(m_lfsr);
            lane_q.push_back(lane);
            plane = next_lane(lane);
            pend = 1'b1;
         end
      end
      checks++;
      if (pulses != 10 || score != 10) begin
         errors++; $display("FAIL chain_count: got pulses=%0d score=%0d, need 10/10", pulses, score);
      end
      checks++;
      if (active !== 1'b0 || crash !== 1'b0) begin
         errors++; $display("FAIL chain_halt: got active=%b crash=%b, need 0/0", active, crash);
      end
   endtask

   task automatic test_lane3_async();
      logic [1:0] lane;
      bit ok, found;
      logic [3:0] row_before;
      do_reset();
      start_game(lane, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL l3_spawn_timeout: got no SPAWN, need SPAWN"); end
      plane = (lane == 2'd2) ? 2'd3 : next_lane(lane);
      found = 1'b0;
      for (int i = 0; i < 20 * ((Y + 1) * T + 1); i++) begin
         @(negedge clk);
         if (crash === 1'b1) begin found = 1'b1; break; end
         if (score_pulse === 1'b1) begin
            lane = map_lane(m_lfsr);
            plane = (lane == 2'd2) ? 2'd3 : next_lane(lane);
         end
      end
      checks++;
      if (!found || obs_lane !== 2'd2 || obs_row !== 4'(PR)) begin
         errors++;
         $display("FAIL lane3_crash: got found=%b lane=%0d row=%0d, need 1/2/%0d", found, obs_lane, obs_row, PR);
      end
      do_reset();
      start_game(lane, ok);
      plane = next_lane(lane);
      repeat (T + 2) @(negedge clk);
      row_before = obs_row;
      checks++;
      if (row_before !== 4'd1 || active !== 1'b1) begin
         errors++; $display("FAIL async_pre: got row=%0d active=%b, need 1/1", row_before, active);
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({obs_lane, obs_row, score_pulse, crash, active} !== 9'd0) begin
         errors++;
         $display("FAIL async_reset: got lane=%0d row=%0d pulse=%b crash=%b active=%b, need all 0",
                  obs_lane, obs_row, score_pulse, crash, active);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pass();
      test_crash();
      test_steer();
      test_gameover_pass();
      test_gameover_idle();
      test_score_chain();
      test_lane3_async();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by 500000 time units, need completion");
      $fatal(1, "watchdog expired");
   end

endmodule
